pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the enable and bubble/flush controls of the PC register and the F/D, D/X and X/M pipeline latches. It resolves three conditions: load-use hazards, taken branches/jumps resolved in X, and fixed-latency multi-cycle multiply/divide operations occupying X. State updates on the rising edge. Outputs are valid before the falling edge on which the latches capture.

Parameters:
REG_AW, 5, register-address width
MD_LAT, 33, multdiv latency in cycles from md_start to result valid (range 2..255)

Ports:
clock  in  1  system clock; controller state on posedge
reset  in  1  asynchronous, active-low (0 = reset asserted)
d_rs1  in  REG_AW  rs1 of instruction in D
d_rs2  in  REG_AW  rs2 of instruction in D
d_use_rs1  in  1  D instruction reads rs1
d_use_rs2  in  1  D instruction reads rs2
x_rd  in  REG_AW  rd of instruction in X
x_is_load  in  1  X instruction is a load
x_is_md  in  1  X instruction is mul/div
x_br_taken  in  1  X instruction redirects PC (taken branch/jal/jalr)
pc_en  out  1  PC register update enable
fd_en  out  1  F/D latch capture enable
dx_en  out  1  D/X latch capture enable
fd_flush  out  1  F/D latch loads NOP
dx_bubble  out  1  D/X latch loads NOP
xm_bubble  out  1  X/M latch loads NOP
md_start  out  1  one-cycle start pulse to multdiv unit
md_busy  out  1  multdiv in flight (state MD_BUSY)

Behaviour:
- States: RUN, MD_BUSY, MD_DONE. 8-bit down-counter md_cnt.
- Reset (reset==0, async): state=RUN, md_cnt=0. While asserted: pc_en=fd_en=dx_en=0; fd_flush=dx_bubble=xm_bubble=md_start=md_busy=0. Reset mid-multdiv aborts it without a done cycle.
- Outputs are combinational from state and inputs. Latency to the latches is zero cycles.
- Load-use hazard: x_is_load && x_rd!=0 && ((d_use_rs1 && d_rs1==x_rd) || (d_use_rs2 && d_rs2==x_rd)).
- RUN, x_is_md=1:
  - md_start=1; pc_en=fd_en=dx_en=0; xm_bubble=1.
  - Next state MD_BUSY, md_cnt=MD_LAT-2.
  - The multdiv check takes priority over the branch and hazard checks (a multdiv instruction is never a branch).
- RUN, x_br_taken=1: pc_en=fd_en=dx_en=1; fd_flush=1, dx_bubble=1. Branch overrides load-use.
- RUN, load-use: pc_en=fd_en=0; dx_en=1; dx_bubble=1. Single-cycle bubble, no state.
- RUN, otherwise: all enables 1, all bubbles 0.
- MD_BUSY:
  - md_busy=1; pc_en=fd_en=dx_en=0; xm_bubble=1; md_start=0.
  - md_cnt decrements each cycle. At md_cnt==0, next state MD_DONE.
- MD_DONE:
  - Result valid; X instruction advances.
  - pc_en=fd_en=dx_en=1; xm_bubble=0; md_start=0, even though x_is_md is still 1 this cycle.
  - Load-use and branch rules apply as in RUN. Next state RUN.
- Total X occupancy for one multdiv instruction: MD_LAT cycles (1 start + MD_LAT-2 busy + 1 done).
- Back-to-back multdiv instructions: the second reaches X after MD_DONE and restarts the sequence from RUN.
- Outputs never assert a flush/bubble and the corresponding enable=0 simultaneously, except xm_bubble, since the X/M latch has no enable.

Optional Feature:
HAZ_STALL_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0].
  - stall_cycles increments on every cycle with pc_en==0 outside reset.
  - flush_events increments on every cycle with fd_flush==1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg holds:
  - state encoding typedef md_state_t {RUN, MD_BUSY, MD_DONE}
  - REG_AW default
  - NOP encoding constant 32'h00000013, consumed by the latches when a bubble or flush is asserted
- One natural sub-module, hazard_detect: purely combinational load-use comparator instantiated inside.
- The state machine stays in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with x_is_md=1 -> all outputs 0, md_start never pulses; release -> md_start=1 on the first cycle.
- Load-use: x_is_load=1, x_rd=5, d_use_rs2=1, d_rs2=5 -> one cycle of pc_en=0, fd_en=0, dx_bubble=1; repeat with x_rd=0 -> no stall.
- Branch vs hazard: x_br_taken=1 with a concurrent load-use condition -> fd_flush=1, dx_bubble=1, pc_en=1.
- Multdiv: MD_LAT=4, x_is_md held at 1 -> md_start for 1 cycle, md_busy for 2 cycles, MD_DONE with dx_en=1 and xm_bubble=0, no second md_start; total 4 cycles.
- Abort: assert reset in the 2nd MD_BUSY cycle -> immediate RUN, md_busy=0; after release with x_is_md=0 -> normal flow with all enables 1.
- With HAZ_STALL_CNT_EN: 3 load-use stalls plus 1 multdiv (MD_LAT=4) -> stall_cycles=6 (3 + 3 multdiv stall cycles), flush_events=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline control path.
//   md_state_t : multdiv sequencer states (RUN, MD_BUSY, MD_DONE)
//   REG_AW_DEF : default register-address width
//   NOP_INSN   : encoding the pipeline latches load when a bubble/flush is set
//                (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int          REG_AW_DEF = 5;
   localparam logic [31:0] NOP_INSN   = 32'h00000013;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational load-use comparator. Flags when the instruction in D
// reads a register that the load currently in X has not yet produced.
// Writes to x0 never create a dependency.
// Ports:
//   i_d_rs1, i_d_rs2         source registers of the D instruction
//   i_d_use_rs1, i_d_use_rs2 D instruction actually reads that source
//   i_x_rd                   destination register of the X instruction
//   i_x_is_load              X instruction is a load
//   o_load_use               load-use hazard present
// ---------------------------------------------------------------------------
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] i_d_rs1,
   input  logic [REG_AW-1:0] i_d_rs2,
   input  logic              i_d_use_rs1,
   input  logic              i_d_use_rs2,
   input  logic [REG_AW-1:0] i_x_rd,
   input  logic              i_x_is_load,
   output logic              o_load_use
);

   logic w_rd_nonzero;
   logic w_hit_rs1;
   logic w_hit_rs2;

   assign w_rd_nonzero = (i_x_rd != '0);
   assign w_hit_rs1    = i_d_use_rs1 && (i_d_rs1 == i_x_rd);
   assign w_hit_rs2    = i_d_use_rs2 && (i_d_rs2 == i_x_rd);
   assign o_load_use   = i_x_is_load && w_rd_nonzero && (w_hit_rs1 || w_hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush sequencer for the 5-stage pipeline. Drives the PC
// enable and the enable/NOP controls of the F/D, D/X and X/M latches for
// load-use hazards, taken branches resolved in X and fixed-latency multdiv
// operations occupying X. State updates on posedge; outputs are
// combinational so they settle before the latches capture on the falling
// edge.
// Optional build macro: HAZ_STALL_CNT_EN adds stall_cycles/flush_events
// saturating performance counters.
// Ports:
//   clock, reset (async, active-low)
//   d_rs1, d_rs2, d_use_rs1, d_use_rs2   D-stage source operands
//   x_rd, x_is_load, x_is_md, x_br_taken X-stage instruction info
//   pc_en, fd_en, dx_en                  capture enables
//   fd_flush, dx_bubble, xm_bubble       load-NOP controls
//   md_start, md_busy                    multdiv handshake
//   stall_cycles, flush_events           (HAZ_STALL_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int MD_LAT = 33
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [REG_AW-1:0] d_rs1,
   input  logic [REG_AW-1:0] d_rs2,
   input  logic              d_use_rs1,
   input  logic              d_use_rs2,
   input  logic [REG_AW-1:0] x_rd,
   input  logic              x_is_load,
   input  logic              x_is_md,
   input  logic              x_br_taken,
   output logic              pc_en,
   output logic              fd_en,
   output logic              dx_en,
   output logic              fd_flush,
   output logic              dx_bubble,
   output logic              xm_bubble,
   output logic              md_start,
   output logic              md_busy
`ifdef HAZ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_events
`endif
);

   // Busy cycles between the start cycle and the done cycle.
   localparam logic [7:0] MD_BUSY_CNT = 8'(MD_LAT - 2);

   md_state_t  r_state;
   md_state_t  w_state_nxt;
   logic [7:0] r_md_cnt;
   logic [7:0] w_md_cnt_nxt;

   logic w_load_use;
   logic w_pc_en;
   logic w_fd_en;
   logic w_dx_en;
   logic w_fd_flush;
   logic w_dx_bubble;
   logic w_xm_bubble;
   logic w_md_start;
   logic w_md_busy;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .i_d_rs1     (d_rs1),
      .i_d_rs2     (d_rs2),
      .i_d_use_rs1 (d_use_rs1),
      .i_d_use_rs2 (d_use_rs2),
      .i_x_rd      (x_rd),
      .i_x_is_load (x_is_load),
      .o_load_use  (w_load_use)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state  <= RUN;
         r_md_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_md_cnt <= w_md_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_md_cnt_nxt = r_md_cnt;
      w_pc_en      = 1'b1;
      w_fd_en      = 1'b1;
      w_dx_en      = 1'b1;
      w_fd_flush   = 1'b0;
      w_dx_bubble  = 1'b0;
      w_xm_bubble  = 1'b0;
      w_md_start   = 1'b0;
      w_md_busy    = 1'b0;

      case (r_state)
         RUN: begin
            if (x_is_md) begin
               w_md_start   = 1'b1;
               w_pc_en      = 1'b0;
               w_fd_en      = 1'b0;
               w_dx_en      = 1'b0;
               w_xm_bubble  = 1'b1;
               w_md_cnt_nxt = MD_BUSY_CNT;
               // With the minimum latency there are no busy cycles at all.
               w_state_nxt  = (MD_LAT == 2) ? MD_DONE : MD_BUSY;
            end else if (x_br_taken) begin
               w_fd_flush  = 1'b1;
               w_dx_bubble = 1'b1;
            end else if (w_load_use) begin
               w_pc_en     = 1'b0;
               w_fd_en     = 1'b0;
               w_dx_bubble = 1'b1;
            end
         end

         MD_BUSY: begin
            w_md_busy    = 1'b1;
            w_pc_en      = 1'b0;
            w_fd_en      = 1'b0;
            w_dx_en      = 1'b0;
            w_xm_bubble  = 1'b1;
            w_md_cnt_nxt = r_md_cnt - 8'd1;
            // Counter holds the busy cycles still to go including this one;
            // the last busy cycle hands over to the done cycle.
            if (r_md_cnt <= 8'd1) begin
               w_state_nxt = MD_DONE;
            end
         end

         MD_DONE: begin
            // x_is_md is still high here but belongs to the finishing
            // instruction, so no restart is issued.
            w_state_nxt = RUN;
            if (x_br_taken) begin
               w_fd_flush  = 1'b1;
               w_dx_bubble = 1'b1;
            end else if (w_load_use) begin
               w_pc_en     = 1'b0;
               w_fd_en     = 1'b0;
               w_dx_bubble = 1'b1;
            end
         end

         default: begin
            w_state_nxt = RUN;
         end
      endcase
   end

   // Everything is forced low while reset is held, independent of inputs.
   assign pc_en     = reset & w_pc_en;
   assign fd_en     = reset & w_fd_en;
   assign dx_en     = reset & w_dx_en;
   assign fd_flush  = reset & w_fd_flush;
   assign dx_bubble = reset & w_dx_bubble;
   assign xm_bubble = reset & w_xm_bubble;
   assign md_start  = reset & w_md_start;
   assign md_busy   = reset & w_md_busy;

`ifdef HAZ_STALL_CNT_EN
   logic [31:0] r_stall_cycles;
   logic [31:0] r_flush_events;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= '0;
         r_flush_events <= '0;
      end else begin
         if (!pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (fd_flush && (r_flush_events != 32'hFFFF_FFFF)) begin
            r_flush_events <= r_flush_events + 32'd1;
         end
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_events = r_flush_events;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int AW = 5;

   logic          clock;
   logic          reset;
   logic [AW-1:0] d_rs1;
   logic [AW-1:0] d_rs2;
   logic          d_use_rs1;
   logic          d_use_rs2;
   logic [AW-1:0] x_rd;
   logic          x_is_load;
   logic          x_is_md;
   logic          x_br_taken;
   logic          pc_en;
   logic          fd_en;
   logic          dx_en;
   logic          fd_flush;
   logic          dx_bubble;
   logic          xm_bubble;
   logic          md_start;
   logic          md_busy;
`ifdef HAZ_STALL_CNT_EN
   logic [31:0]   stall_cycles;
   logic [31:0]   flush_events;
`endif

   int tests = 0;
   int fails = 0;

   pipeline_hazard_ctrl #(
      .REG_AW (AW),
      .MD_LAT (4)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .d_rs1      (d_rs1),
      .d_rs2      (d_rs2),
      .d_use_rs1  (d_use_rs1),
      .d_use_rs2  (d_use_rs2),
      .x_rd       (x_rd),
      .x_is_load  (x_is_load),
      .x_is_md    (x_is_md),
      .x_br_taken (x_br_taken),
      .pc_en      (pc_en),
      .fd_en      (fd_en),
      .dx_en      (dx_en),
      .fd_flush   (fd_flush),
      .dx_bubble  (dx_bubble),
      .xm_bubble  (xm_bubble),
      .md_start   (md_start),
      .md_busy    (md_busy)
`ifdef HAZ_STALL_CNT_EN
      ,
      .stall_cycles (stall_cycles),
      .flush_events (flush_events)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Expected output order: {pc_en, fd_en, dx_en, fd_flush, dx_bubble,
   // xm_bubble, md_start, md_busy}
   localparam logic [7:0] E_ZERO  = 8'b000_000_00;
   localparam logic [7:0] E_RUN   = 8'b111_000_00;
   localparam logic [7:0] E_LU    = 8'b001_010_00;
   localparam logic [7:0] E_BR    = 8'b111_110_00;
   localparam logic [7:0] E_START = 8'b000_001_10;
   localparam logic [7:0] E_BUSY  = 8'b000_001_01;

   typedef struct {
      string         name;
      logic          rst_n;
      logic [AW-1:0] rs1;
      logic [AW-1:0] rs2;
      logic          u1;
      logic          u2;
      logic [AW-1:0] rd;
      logic          ld;
      logic          md;
      logic          br;
      logic [7:0]    exp;
   } vec_t;

   logic [7:0] exp_q[$];
   vec_t       tbl[9];

   function automatic vec_t mk(input string name, input logic rst_n,
                               input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                               input logic u1, input logic u2,
                               input logic [AW-1:0] rd, input logic ld,
                               input logic md, input logic br,
                               input logic [7:0] exp);
      vec_t v;
      v.name = name; v.rst_n = rst_n; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.rd = rd; v.ld = ld; v.md = md; v.br = br;
      v.exp = exp;
      return v;
   endfunction

   // Drive one cycle of stimulus just after posedge, check at negedge.
   task automatic run(input vec_t v);
      logic [7:0] want;
      logic [7:0] got;
      @(posedge clock);
      #1;
      reset      = v.rst_n;
      d_rs1      = v.rs1;
      d_rs2      = v.rs2;
      d_use_rs1  = v.u1;
      d_use_rs2  = v.u2;
      x_rd       = v.rd;
      x_is_load  = v.ld;
      x_is_md    = v.md;
      x_br_taken = v.br;
      exp_q.push_back(v.exp);
      @(negedge clock);
      want = exp_q.pop_front();
      got  = {pc_en, fd_en, dx_en, fd_flush, dx_bubble, xm_bubble, md_start, md_busy};
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %b expected %b (pc fd dx fl bub xm st busy)",
                  v.name, got, want);
      end
   endtask

   task automatic idle(input string name);
      run(mk(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN));
   endtask

`ifdef HAZ_STALL_CNT_EN
   task automatic check_cnt(input string name, input logic [31:0] got,
                            input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
`endif

   initial begin
      reset = 1'b0; d_rs1 = '0; d_rs2 = '0; d_use_rs1 = 1'b0; d_use_rs2 = 1'b0;
      x_rd = '0; x_is_load = 1'b0; x_is_md = 1'b0; x_br_taken = 1'b0;

      tbl[0] = mk("idle",          1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN);
      tbl[1] = mk("lu_rs2",        1, 0, 5, 0, 1, 5, 1, 0, 0, E_LU);
      tbl[2] = mk("lu_rd0",        1, 0, 0, 0, 1, 0, 1, 0, 0, E_RUN);
      tbl[3] = mk("lu_rs1",        1, 7, 0, 1, 0, 7, 1, 0, 0, E_LU);
      tbl[4] = mk("rs1_not_used",  1, 7, 0, 0, 0, 7, 1, 0, 0, E_RUN);
      tbl[5] = mk("rd_mismatch",   1, 6, 6, 1, 1, 7, 1, 0, 0, E_RUN);
      tbl[6] = mk("match_no_load", 1, 9, 9, 1, 1, 9, 0, 0, 0, E_RUN);
      tbl[7] = mk("branch",        1, 0, 0, 0, 0, 0, 0, 0, 1, E_BR);
      tbl[8] = mk("branch_over_lu",1, 0, 5, 0, 1, 5, 1, 0, 1, E_BR);

      // Reset held with a multdiv waiting in X: nothing may fire.
      for (int i = 0; i < 3; i++)
         run(mk("reset_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));

      // Release: multdiv sequence of 4 cycles, no second start in done.
      run(mk("md_start",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_START));
      run(mk("md_busy1",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("md_busy2",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("md_done",   1, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN));
      idle("after_md");

      for (int i = 0; i < 9; i++) run(tbl[i]);

      // Back-to-back multdiv: second one restarts after done.
      run(mk("b2b_start1", 1, 0, 0, 0, 0, 0, 0, 1, 0, E_START));
      run(mk("b2b_busy1",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("b2b_busy2",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("b2b_done",   1, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN));
      run(mk("b2b_start2", 1, 0, 0, 0, 0, 0, 0, 1, 0, E_START));
      run(mk("abort_busy1",1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));

      // Abort in the second busy cycle, then resume without multdiv.
      run(mk("abort_rst",  0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
      run(mk("abort_hold", 0, 0, 0, 0, 0, 0, 0, 1, 0, E_ZERO));
      idle("abort_resume");
      idle("abort_resume2");

      // Load-use in the done cycle stalls the front end.
      run(mk("lu_start",   1, 0, 0, 0, 0, 0, 0, 1, 0, E_START));
      run(mk("lu_busy1",   1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("lu_busy2",   1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("lu_in_done", 1, 3, 0, 1, 0, 3, 1, 1, 0, E_LU));
      idle("lu_after_done");

`ifdef HAZ_STALL_CNT_EN
      run(mk("cnt_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO));
      idle("cnt_release");
      for (int i = 0; i < 3; i++)
         run(mk("cnt_lu", 1, 0, 5, 0, 1, 5, 1, 0, 0, E_LU));
      run(mk("cnt_md_start", 1, 0, 0, 0, 0, 0, 0, 1, 0, E_START));
      run(mk("cnt_md_busy1", 1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("cnt_md_busy2", 1, 0, 0, 0, 0, 0, 0, 1, 0, E_BUSY));
      run(mk("cnt_md_done",  1, 0, 0, 0, 0, 0, 0, 1, 0, E_RUN));
      idle("cnt_idle");
      check_cnt("stall_cycles", stall_cycles, 32'd6);
      check_cnt("flush_events", flush_events, 32'd0);
      run(tbl[7]);
      idle("cnt_idle2");
      check_cnt("flush_events_br", flush_events, 32'd1);
      check_cnt("stall_cycles_br", stall_cycles, 32'd6);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
